// File: rtl/inv_clark_pkg.sv
// Shared constants and FSM encoding for the FOC voltage-path transforms.
// The Clarke block uses the same constants, so both transforms take them from one place.
package inv_clark_pkg;

   localparam int unsigned DW_DEF          = 12;   // signed data width
   localparam int unsigned KW_DEF          = 10;   // fractional bits of scale constants
   localparam int unsigned K_SQRT3_2_DEF   = 886;  // round(sqrt(3)/2 * (2^KW-1))
   localparam int unsigned K_INV_SQRT3_DEF = 591;  // 1/sqrt(3), used by the Clarke block

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_SUM  = 2'd2,
      S_OUT  = 2'd3
   } ic_state_t;

endpackage

// File: rtl/foc_sat.sv
// Parameterised signed saturator: clamps an IW-bit signed value into OW bits.
// Combinational; reusable by inverse Park and SVPWM.
module foc_sat #(
   parameter int unsigned IW = 14,
   parameter int unsigned OW = 12
) (
   input  logic signed [IW-1:0] din,
   output logic signed [OW-1:0] dout
);

   // In range when every bit above the output sign bit equals that sign bit.
   always_comb begin
      dout = din[OW-1:0];
      if (!((din[IW-1:OW-1] == '0) || (din[IW-1:OW-1] == '1))) begin
         dout = din[IW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
      end
   end

endmodule

// File: rtl/inv_clark.sv
// Inverse Clarke transform (amplitude-invariant):
//   Va = alpha, Vb = -alpha/2 + sqrt(3)/2*beta, Vc = -alpha/2 - sqrt(3)/2*beta.
// One multiplier, serialised by a 4-state FSM; start on rising edge of iC_en.
module inv_clark
   import inv_clark_pkg::*;
#(
   parameter int unsigned       DW        = DW_DEF,
   parameter int unsigned       KW        = KW_DEF,
   parameter logic [KW-1:0]     K_SQRT3_2 = KW'(K_SQRT3_2_DEF)
) (
   input  logic                 iClk,
   input  logic                 iRst_n,
   input  logic                 iC_en,
   input  logic signed [DW-1:0] iValpha,
   input  logic signed [DW-1:0] iVbeta,
   output logic signed [DW-1:0] oVa,
   output logic signed [DW-1:0] oVb,
   output logic signed [DW-1:0] oVc,
   output logic                 oC_done
);

   localparam int unsigned PW = DW + KW + 1;  // product width
   localparam int unsigned RW = DW + 2;       // pre-saturation sum width

   ic_state_t              state_q, state_d;
   logic                   en_q;
   logic                   start;
   logic signed [DW-1:0]   a_r, b_r;
   logic signed [PW-1:0]   prod;
   logic signed [RW-1:0]   h_w, s_w;
   logic signed [RW-1:0]   vb_raw, vc_raw;
   logic signed [DW-1:0]   vb_sat, vc_sat;
   logic                   unused_prod_lsb;

   assign start = iC_en & ~en_q;

   // Floored arithmetic shifts, sign-extended to the sum width; the product's
   // fractional bits are discarded by the shift.
   always_comb begin
      h_w = {{3{a_r[DW-1]}}, a_r[DW-1:1]};
      s_w = {prod[PW-1], prod[PW-1:KW]};
   end
   assign unused_prod_lsb = ^prod[KW-1:0];

   // Edge-detect register: follows iC_en every clock regardless of state.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) en_q <= 1'b0;
      else         en_q <= iC_en;
   end

   // FSM state register.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic; starts outside S_IDLE are dropped.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (start) state_d = S_MUL;
         S_MUL:  state_d = S_SUM;
         S_SUM:  state_d = S_OUT;
         S_OUT:  state_d = S_IDLE;
      endcase
   end

   // Datapath: latch inputs, multiply, sum, register saturated outputs.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         a_r     <= '0;
         b_r     <= '0;
         prod    <= '0;
         vb_raw  <= '0;
         vc_raw  <= '0;
         oVa     <= '0;
         oVb     <= '0;
         oVc     <= '0;
         oC_done <= 1'b0;
      end else begin
         oC_done <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  a_r <= iValpha;
                  b_r <= iVbeta;
               end
            end
            S_MUL: prod <= PW'(b_r) * PW'($signed({1'b0, K_SQRT3_2}));
            S_SUM: begin
               vb_raw <= s_w - h_w;
               vc_raw <= -h_w - s_w;
            end
            S_OUT: begin
               oVa     <= a_r;
               oVb     <= vb_sat;
               oVc     <= vc_sat;
               oC_done <= 1'b1;
            end
         endcase
      end
   end

   foc_sat #(.IW(RW), .OW(DW)) u_sat_vb (.din(vb_raw), .dout(vb_sat));
   foc_sat #(.IW(RW), .OW(DW)) u_sat_vc (.din(vc_raw), .dout(vc_sat));

endmodule

// File: tb/tb_inv_clark.sv
// Self-checking bench for inv_clark: directed vector table, multi-cycle corner
// sequences and a random sweep, all checked through an expected-result queue.
module tb_inv_clark;

   logic               iClk;
   logic               iRst_n;
   logic               iC_en;
   logic signed [11:0] iValpha;
   logic signed [11:0] iVbeta;
   logic signed [11:0] oVa, oVb, oVc;
   logic               oC_done;

   inv_clark #(.DW(12), .KW(10), .K_SQRT3_2(10'd886)) dut (
      .iClk    (iClk),
      .iRst_n  (iRst_n),
      .iC_en   (iC_en),
      .iValpha (iValpha),
      .iVbeta  (iVbeta),
      .oVa     (oVa),
      .oVb     (oVb),
      .oVc     (oVc),
      .oC_done (oC_done)
   );

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   int cyc = 0;
   always @(posedge iClk) cyc++;

   typedef struct {
      int va;
      int vb;
      int vc;
      int due;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      int a;
      int b;
      int va;
      int vb;
      int vc;
   } vec_t;

   int n_pass   = 0;
   int n_total  = 0;
   int done_cnt = 0;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic int clamp12(input int x);
      if (x > 2047)  return 2047;
      if (x < -2048) return -2048;
      return x;
   endfunction

   // Reference: floor(alpha/2), floor(beta*886/1024), then clamp.
   function automatic void model(input int a, input int b,
                                 output int va, output int vb, output int vc);
      int h, s;
      h  = a >>> 1;
      s  = (b * 886) >>> 10;
      va = a;
      vb = clamp12(s - h);
      vc = clamp12(-h - s);
   endfunction

   // Output monitor: every done pulse must match the oldest pending result.
   always @(negedge iClk) begin
      if (iRst_n && oC_done) begin
         exp_t e;
         done_cnt++;
         if (sb.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_done: oC_done=1 at cycle %0d, expected 0", cyc);
         end else begin
            e = sb.pop_front();
            check("latency", cyc, e.due);
            check("va", int'(oVa), e.va);
            check("vb", int'(oVb), e.vb);
            check("vc", int'(oVc), e.vc);
         end
      end
   end

   // Raise iC_en for one cycle with the given inputs and queue the expected result.
   task automatic send(input int a, input int b, input int va, input int vb, input int vc);
      exp_t e;
      @(negedge iClk);
      iValpha = 12'(a);
      iVbeta  = 12'(b);
      iC_en   = 1'b1;
      e.va = va; e.vb = vb; e.vc = vc; e.due = cyc + 4;
      sb.push_back(e);
      @(negedge iClk);
      iC_en = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge iClk);
      if (sb.size() > 0) begin
         n_total++;
         $display("FAIL drain_timeout: %0d results pending, expected 0", sb.size());
         sb.delete();
      end
      repeat (2) @(negedge iClk);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge iClk);
   endtask

   task automatic check_zero(input string name);
      check({name, "_va"},   int'(oVa), 0);
      check({name, "_vb"},   int'(oVb), 0);
      check({name, "_vc"},   int'(oVc), 0);
      check({name, "_done"}, int'(oC_done), 0);
   endtask

   initial begin
      vec_t vecs[6];
      int   d0;
      int   a, b, va, vb, vc;

      vecs[0] = '{a:  1000, b:     0, va:  1000, vb: -500, vc:  -500};
      vecs[1] = '{a:     0, b:  1000, va:     0, vb:  865, vc:  -865};
      vecs[2] = '{a: -2048, b: -2048, va: -2048, vb: -748, vc:  2047};
      vecs[3] = '{a:  1001, b:    -1, va:  1001, vb: -501, vc:  -499};
      vecs[4] = '{a:  2047, b:  2047, va:  2047, vb:  748, vc: -2048};
      vecs[5] = '{a:    -1, b:     1, va:    -1, vb:    1, vc:     1};

      iRst_n  = 1'b0;
      iC_en   = 1'b0;
      iValpha = '0;
      iVbeta  = '0;
      idle(3);
      check_zero("rst_hold");
      iRst_n = 1'b1;
      idle(2);
      check_zero("rst_release");

      // Directed vectors.
      for (int i = 0; i < 6; i++) begin
         send(vecs[i].a, vecs[i].b, vecs[i].va, vecs[i].vb, vecs[i].vc);
         drain();
      end

      // Level held high produces a single result.
      d0 = done_cnt;
      @(negedge iClk);
      iValpha = 12'sd300; iVbeta = 12'sd200; iC_en = 1'b1;
      model(300, 200, va, vb, vc);
      sb.push_back('{va: va, vb: vb, vc: vc, due: cyc + 4});
      idle(10);
      iC_en = 1'b0;
      drain();
      check("held_en_done_count", done_cnt - d0, 1);

      // Second edge 2 cycles after the first is dropped.
      d0 = done_cnt;
      model(-700, 900, va, vb, vc);
      send(-700, 900, va, vb, vc);
      @(negedge iClk);
      iValpha = 12'sd5; iVbeta = 12'sd5; iC_en = 1'b1;
      @(negedge iClk);
      iC_en = 1'b0;
      drain();
      check("early_edge_done_count", done_cnt - d0, 1);

      // Edge exactly 4 cycles after the first is accepted.
      d0 = done_cnt;
      model(123, -456, va, vb, vc);
      send(123, -456, va, vb, vc);
      idle(2);
      model(-321, 654, va, vb, vc);
      send(-321, 654, va, vb, vc);
      drain();
      check("back_to_back_done_count", done_cnt - d0, 2);

      // Input change during S_MUL does not disturb the latched operands.
      model(1500, -1200, va, vb, vc);
      send(1500, -1200, va, vb, vc);
      iValpha = -12'sd9; iVbeta = 12'sd77;
      drain();

      // Asynchronous reset in S_SUM discards the computation.
      @(negedge iClk);
      iValpha = 12'sd1000; iVbeta = 12'sd1000; iC_en = 1'b1;
      @(negedge iClk);
      iC_en = 1'b0;
      @(negedge iClk);
      iRst_n = 1'b0;
      #1;
      check_zero("rst_mid_sum");
      idle(2);
      iRst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge iClk);
         check_zero("post_rst");
      end
      send(vecs[0].a, vecs[0].b, vecs[0].va, vecs[0].vb, vecs[0].vc);
      drain();

      // Random sweep at the minimum start interval.
      for (int i = 0; i < 10000; i++) begin
         a = int'($signed(12'($urandom_range(4095))));
         b = int'($signed(12'($urandom_range(4095))));
         model(a, b, va, vb, vc);
         send(a, b, va, vb, vc);
         idle(2);
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
